// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Two-port (instruction fetch / data) arbiter in front of a single
//            shared single-port memory. One transaction at a time; contended
//            requests alternate between the ports. A per-transaction wait
//            counter aborts a grant the memory never acknowledges.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   i_req_i / i_addr_i   fetch request and address (read only)
//   i_ack_o / i_data_o   fetch completion pulse and held read data
//   d_req_i / d_we_i     data request and write enable
//   d_addr_i / d_data_i  data address and write data
//   d_ack_o / d_data_o   data completion pulse and held read data
//   err_o                qualifies an ack as a timed-out transaction
//   m_req_o .. m_data_o  registered memory request, write enable, addr, data
//   m_ack_i / m_data_i   memory completion and read data
//   gnt_o                current owner: 00 none, 01 fetch, 10 data
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_ack_o,
  output logic [DATA_W-1:0] i_data_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_data_i,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_data_o,
  output logic              err_o,
  output logic              m_req_o,
  output logic              m_we_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_data_o,
  input  logic              m_ack_i,
  input  logic [DATA_W-1:0] m_data_i,
  output logic [1:0]        gnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT_I = 2'd1,
    S_GNT_D = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Last wait-counter value allowed before the grant is abandoned; this
  // gives exactly TIMEOUT grant cycles.
  localparam logic [15:0] c_timeout_last = 16'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_d;     // 1: most recent grant went to the data port
  logic                r_err;        // RESP was entered through a timeout
  logic [15:0]         r_wait_cnt;
  logic                r_m_req;
  logic                r_m_we;
  logic [ADDR_W-1:0]   r_m_addr;
  logic [DATA_W-1:0]   r_m_data;
  logic [DATA_W-1:0]   r_i_data;
  logic [DATA_W-1:0]   r_d_data;
  logic                w_grant_i;
  logic                w_grant_d;
  logic                w_done;
  logic                w_timeout;
  logic                w_in_gnt;

  assign w_in_gnt = (r_state == S_GNT_I) || (r_state == S_GNT_D);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req_i && d_req_i) begin
          // Contention: serve whichever port did not win last time.
          w_grant_i = r_last_d;
          w_grant_d = !r_last_d;
        end else begin
          w_grant_i = i_req_i;
          w_grant_d = d_req_i;
        end
      end
      S_GNT_I, S_GNT_D: begin
        // An ack in the final allowed cycle still wins over the timeout.
        if (m_ack_i) begin
          w_done = 1'b1;
        end else if (r_wait_cnt == c_timeout_last) begin
          w_timeout = 1'b1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_grant_i) begin
      w_state_nxt = S_GNT_I;
    end else if (w_grant_d) begin
      w_state_nxt = S_GNT_D;
    end
    if (w_done || w_timeout) begin
      w_state_nxt = S_RESP;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_last_d   <= 1'b1;
      r_err      <= 1'b0;
      r_wait_cnt <= 16'd0;
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= '0;
      r_m_data   <= '0;
      r_i_data   <= '0;
      r_d_data   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_m_req <= (w_state_nxt == S_GNT_I) || (w_state_nxt == S_GNT_D);
      r_err   <= w_timeout;

      if (w_in_gnt && !m_ack_i) begin
        r_wait_cnt <= r_wait_cnt + 16'd1;
      end

      // Request fields are captured once at the grant edge and then held,
      // so the memory sees a stable request regardless of the requester.
      if (w_grant_i) begin
        r_m_addr   <= i_addr_i;
        r_m_we     <= 1'b0;
        r_last_d   <= 1'b0;
        r_wait_cnt <= 16'd0;
      end else if (w_grant_d) begin
        r_m_addr   <= d_addr_i;
        r_m_we     <= d_we_i;
        r_m_data   <= d_data_i;
        r_last_d   <= 1'b1;
        r_wait_cnt <= 16'd0;
      end

      if (w_done) begin
        if (r_state == S_GNT_I) begin
          r_i_data <= m_data_i;
        end else if (!r_m_we) begin
          r_d_data <= m_data_i;
        end
      end
    end
  end

  // During RESP the owner is the most recent grant.
  always_comb begin
    gnt_o = 2'b00;
    case (r_state)
      S_GNT_I: gnt_o = 2'b01;
      S_GNT_D: gnt_o = 2'b10;
      S_RESP:  gnt_o = {r_last_d, !r_last_d};
      default: gnt_o = 2'b00;
    endcase
  end

  assign i_ack_o  = (r_state == S_RESP) && !r_last_d;
  assign d_ack_o  = (r_state == S_RESP) && r_last_d;
  assign err_o    = (r_state == S_RESP) && r_err;
  assign i_data_o = r_i_data;
  assign d_data_o = r_d_data;
  assign m_req_o  = r_m_req;
  assign m_we_o   = r_m_we;
  assign m_addr_o = r_m_addr;
  assign m_data_o = r_m_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed, table-driven bench for mem_port_arbiter (TIMEOUT=4),
//            plus hand-written sequences for timeout and mid-op reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic        i_ack_o;
  logic [31:0] i_data_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_data_i;
  logic        d_ack_o;
  logic [31:0] d_data_o;
  logic        err_o;
  logic        m_req_o;
  logic        m_we_o;
  logic [31:0] m_addr_o;
  logic [31:0] m_data_o;
  logic        m_ack_i;
  logic [31:0] m_data_i;
  logic [1:0]  gnt_o;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(4)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_req_i (i_req_i),
    .i_addr_i(i_addr_i),
    .i_ack_o (i_ack_o),
    .i_data_o(i_data_o),
    .d_req_i (d_req_i),
    .d_we_i  (d_we_i),
    .d_addr_i(d_addr_i),
    .d_data_i(d_data_i),
    .d_ack_o (d_ack_o),
    .d_data_o(d_data_o),
    .err_o   (err_o),
    .m_req_o (m_req_o),
    .m_we_o  (m_we_o),
    .m_addr_o(m_addr_o),
    .m_data_o(m_data_o),
    .m_ack_i (m_ack_i),
    .m_data_i(m_data_i),
    .gnt_o   (gnt_o)
  );

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dd;
    logic        ma;
    logic [31:0] md;
    logic [134:0] exp;  // {m_req,m_we,m_addr,m_data,i_ack,i_data,d_ack,d_data,err,gnt}
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic logic [134:0] outs();
    return {m_req_o, m_we_o, m_addr_o, m_data_o, i_ack_o, i_data_o,
            d_ack_o, d_data_o, err_o, gnt_o};
  endfunction

  task automatic add(input logic ir, input logic [31:0] ia, input logic dr,
                     input logic dw, input logic [31:0] da, input logic [31:0] dd,
                     input logic ma, input logic [31:0] md,
                     input logic e_req, input logic e_we, input logic [31:0] e_addr,
                     input logic [31:0] e_mdata, input logic e_iack,
                     input logic [31:0] e_idata, input logic e_dack,
                     input logic [31:0] e_ddata, input logic e_err,
                     input logic [1:0] e_gnt);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.ma = ma; v.md = md;
    v.exp = {e_req, e_we, e_addr, e_mdata, e_iack, e_idata, e_dack, e_ddata,
             e_err, e_gnt};
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [134:0] act, input logic [134:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    i_req_i = 0; i_addr_i = 0; d_req_i = 0; d_we_i = 0; d_addr_i = 0;
    d_data_i = 0; m_ack_i = 0; m_data_i = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // ir ia   dr dw da    dd         ma md        | req we addr  mdata  iack idata  dack ddata  err gnt
    add(1,'h100,0,0,0,     0,         0,0,           1,0,'h100,0,        0,0,      0,0,        0,2'b01);
    add(1,'h100,0,0,0,     0,         0,0,           1,0,'h100,0,        0,0,      0,0,        0,2'b01);
    add(1,'h100,0,0,0,     0,         0,0,           1,0,'h100,0,        0,0,      0,0,        0,2'b01);
    add(1,'h100,0,0,0,     0,         1,'h13,        0,0,'h100,0,        1,'h13,   0,0,        0,2'b01);
    add(1,'h100,0,0,0,     0,         0,0,           0,0,'h100,0,        0,'h13,   0,0,        0,2'b00);
    add(0,0,    0,0,0,     0,         0,0,           0,0,'h100,0,        0,'h13,   0,0,        0,2'b00);
    // write: read data from memory must be ignored
    add(0,0,    1,1,'h2000,'hDEADBEEF,0,0,           1,1,'h2000,'hDEADBEEF,0,'h13, 0,0,        0,2'b10);
    add(0,0,    1,1,'h2000,'hDEADBEEF,1,'h55555555,  0,1,'h2000,'hDEADBEEF,0,'h13, 1,0,        0,2'b10);
    add(0,0,    1,1,'h2000,'hDEADBEEF,0,0,           0,1,'h2000,'hDEADBEEF,0,'h13, 0,0,        0,2'b00);
    // data read with memory ack in the first m_req cycle
    add(0,0,    1,0,'h3000,'h12345678,0,0,           1,0,'h3000,'h12345678,0,'h13, 0,0,        0,2'b10);
    add(0,0,    1,0,'h3000,'h12345678,1,'hCAFEF00D,  0,0,'h3000,'h12345678,0,'h13, 1,'hCAFEF00D,0,2'b10);
    add(0,0,    1,0,'h3000,'h12345678,0,0,           0,0,'h3000,'h12345678,0,'h13, 0,'hCAFEF00D,0,2'b00);
    // spurious memory ack while idle
    add(0,0,    0,0,0,     0,         1,'hFFFFFFFF,  0,0,'h3000,'h12345678,0,'h13, 0,'hCAFEF00D,0,2'b00);
    // contention: alternate I, D, I, D
    add(1,'h400,1,0,'h500, 0,         0,0,           1,0,'h400,'h12345678,0,'h13,  0,'hCAFEF00D,0,2'b01);
    add(1,'h400,1,0,'h500, 0,         1,'hAAA,       0,0,'h400,'h12345678,1,'hAAA, 0,'hCAFEF00D,0,2'b01);
    add(1,'h400,1,0,'h500, 0,         0,0,           0,0,'h400,'h12345678,0,'hAAA, 0,'hCAFEF00D,0,2'b00);
    add(1,'h400,1,0,'h500, 0,         0,0,           1,0,'h500,0,         0,'hAAA, 0,'hCAFEF00D,0,2'b10);
    add(1,'h400,1,0,'h500, 0,         1,'hBBB,       0,0,'h500,0,         0,'hAAA, 1,'hBBB,     0,2'b10);
    add(1,'h400,1,0,'h500, 0,         0,0,           0,0,'h500,0,         0,'hAAA, 0,'hBBB,     0,2'b00);
    add(1,'h400,1,0,'h500, 0,         0,0,           1,0,'h400,0,         0,'hAAA, 0,'hBBB,     0,2'b01);
    add(1,'h400,1,0,'h500, 0,         1,'hCCC,       0,0,'h400,0,         1,'hCCC, 0,'hBBB,     0,2'b01);
    add(0,'h400,1,0,'h500, 0,         0,0,           0,0,'h400,0,         0,'hCCC, 0,'hBBB,     0,2'b00);
    add(0,'h400,1,0,'h500, 0,         0,0,           1,0,'h500,0,         0,'hCCC, 0,'hBBB,     0,2'b10);
    add(0,'h400,1,0,'h500, 0,         1,'hDDD,       0,0,'h500,0,         0,'hCCC, 1,'hDDD,     0,2'b10);
    add(0,0,    0,0,0,     0,         0,0,           0,0,'h500,0,         0,'hCCC, 0,'hDDD,     0,2'b00);
    // requester drops req during grant: transaction still completes
    add(1,'h600,0,0,0,     0,         0,0,           1,0,'h600,0,         0,'hCCC, 0,'hDDD,     0,2'b01);
    add(0,'h600,0,0,0,     0,         0,0,           1,0,'h600,0,         0,'hCCC, 0,'hDDD,     0,2'b01);
    add(0,'h600,0,0,0,     0,         1,'hEEE,       0,0,'h600,0,         1,'hEEE, 0,'hDDD,     0,2'b01);
    add(0,0,    0,0,0,     0,         0,0,           0,0,'h600,0,         0,'hEEE, 0,'hDDD,     0,2'b00);

    idle_inputs();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_outputs", outs(), '0);
    #3 rst_ni = 1'b1;
    @(negedge clk_i);
    step();
    chk("idle_after_reset", outs(), '0);

    foreach (vecs[i]) begin
      i_req_i = vecs[i].ir; i_addr_i = vecs[i].ia;
      d_req_i = vecs[i].dr; d_we_i = vecs[i].dw;
      d_addr_i = vecs[i].da; d_data_i = vecs[i].dd;
      m_ack_i = vecs[i].ma; m_data_i = vecs[i].md;
      step();
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Timeout: 4 grant cycles without ack, then ack with err, data held.
    idle_inputs();
    d_req_i = 1; d_addr_i = 'h700;
    step();
    chk("to_grant", {63'd0, m_req_o, gnt_o}, {63'd0, 1'b1, 2'b10});
    n = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      n++;
      if (d_ack_o) break;
    end
    chk("to_cycles", 135'(n), 135'd4);
    chk("to_resp", {d_ack_o, err_o, m_req_o, d_data_o},
        {1'b1, 1'b1, 1'b0, 32'hDDD});
    d_req_i = 0;
    step();
    chk("to_exit", {err_o, d_ack_o, gnt_o}, {1'b0, 1'b0, 2'b00});

    // Normal service after a timeout.
    i_req_i = 1; i_addr_i = 'h800;
    step();
    m_ack_i = 1; m_data_i = 'h111;
    step();
    chk("post_to_fetch", {i_ack_o, err_o, i_data_o, m_addr_o},
        {1'b1, 1'b0, 32'h111, 32'h800});
    idle_inputs();
    step();

    // Ack arriving in the last allowed grant cycle is a normal completion.
    d_req_i = 1; d_addr_i = 'h900;
    step();
    repeat (3) step();
    chk("last_cycle_still_gnt", {m_req_o, d_ack_o}, {1'b1, 1'b0});
    m_ack_i = 1; m_data_i = 'h999;
    step();
    chk("ack_at_timeout", {d_ack_o, err_o, d_data_o}, {1'b1, 1'b0, 32'h999});
    idle_inputs();
    step();

    // Reset while the data port owns the memory; fetch is also pending.
    d_req_i = 1; d_we_i = 1; d_addr_i = 'hA00; d_data_i = 'h77;
    step();
    chk("rst_pre_gnt", {m_req_o, gnt_o}, {1'b1, 2'b10});
    i_req_i = 1; i_addr_i = 'hB00;
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_async", {m_req_o, gnt_o, d_data_o}, {1'b0, 2'b00, 32'h0});
    m_ack_i = 1;
    step();
    chk("rst_no_ack", {d_ack_o, i_ack_o, m_req_o}, 3'b000);
    m_ack_i = 0;
    #3 rst_ni = 1'b1;
    step();
    chk("rst_first_grant", {m_req_o, gnt_o, m_addr_o}, {1'b1, 2'b01, 32'hB00});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
